uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DBIT, default 8: data bits per frame.
REQ-002 SHALL have parameter SB_TICK, default 16: s_tick count spanning the stop bit (16 = 1 stop bit).
REQ-003 SHALL have port clk, input, 1: the single clock, all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port rx, input, 1: serial line, idle high, LSB first.
REQ-006 SHALL have port s_tick, input, 1: one-clock oversampling pulse at 16x baud, from the shared timer.
REQ-007 SHALL have port rx_dout, output, DBIT: last received data word.
REQ-008 SHALL have port rx_done_tick, output, 1: one-clock pulse when a frame completes.
REQ-009 SHALL have port frame_err, output, 1: stop bit sampled low on the last frame.
REQ-010 SHALL have port parity_err, output, 1: parity mismatch on the last frame.
REQ-011 SHALL have port state_out, output, 2: current FSM state for debug.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; the FSM uses only the synchronized value rx_s.
REQ-013 SHALL implement FSM states IDLE=0, START=1, DATA=2, STOP=3, plus PARITY when enabled.
REQ-014 SHALL use a 4-bit tick counter s, a bit counter n, and a DBIT shift register b; s advances only on cycles with s_tick=1.
REQ-015 IDLE: on rx_s=0, SHALL go to START with s=0.
REQ-016 START: on s_tick with s=7, SHALL go to DATA with s=0, n=0 if rx_s=0; if rx_s=1, SHALL go to IDLE as glitch rejection, with no done pulse.
REQ-017 DATA: on s_tick with s=15, SHALL shift rx_s into b MSB, shifting right, and set s=0. After the DBIT-th bit it SHALL go to STOP, or to PARITY when enabled.
REQ-018 STOP: on s_tick with s=SB_TICK-1, SHALL load rx_dout<=b, set frame_err<=~rx_s, pulse rx_done_tick for exactly one clock, and return to IDLE.
REQ-019 SHALL update rx_dout even on a framing error.
REQ-020 frame_err and parity_err SHALL hold their value until the next rx_done_tick.
REQ-021 SHALL make a new start detectable in the clock immediately after rx_done_tick; back-to-back frames SHALL be received without loss.
REQ-022 SHALL ignore rx changes between sample points.
REQ-023 SHALL hold state while s_tick=0.

Reset
REQ-024 Asserting reset SHALL immediately force IDLE, s=0, n=0, b=0, synchronizer flops=1, rx_dout=0, rx_done_tick=0, frame_err=0, parity_err=0, state_out=0.
REQ-025 Reset mid-frame SHALL discard the partial frame with no done pulse; reception SHALL restart only on a new falling edge after release.

Configuration
REQ-026 Macro UART_RX_PARITY_EN: when defined, SHALL insert a PARITY state (encoding 3, with STOP moved to encoding 4 and state_out widened to 3) after DATA.
REQ-027 In PARITY, on s_tick with s=15, SHALL sample rx_s as the parity bit and then go to STOP; parity_err SHALL be loaded at rx_done_tick as (^b) ^ parity_bit, even parity.
REQ-028 When UART_RX_PARITY_EN is undefined, SHALL omit the PARITY state, keep state_out at 2 bits, and tie parity_err to 0.

Verification
Bench: s_tick every 16 clk; bit period 256 clk.
REQ-029 Frame 0xA5 (start 0, bits LSB first, stop 1) -> one rx_done_tick, rx_dout=0xA5, frame_err=0.
REQ-030 rx low for 64 clk (4 ticks), then high -> return to IDLE, no rx_done_tick, rx_dout unchanged.
REQ-031 Frame 0x3C with stop bit driven 0 -> rx_done_tick, rx_dout=0x3C, frame_err=1; then a clean 0x81 -> frame_err=0, rx_dout=0x81.
REQ-032 Frames 0x55, 0xAA, 0xFF back-to-back with zero idle -> three rx_done_ticks, in order, data correct.
REQ-033 Reset asserted during data bit 4 of 0xF0 -> all outputs 0 and state_out=0 at once; a following 0x0F is received correctly.
REQ-034 With UART_RX_PARITY_EN, frame 0x07 with parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with a 2-flop input synchronizer, LSB-first data.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err,
`ifdef UART_RX_PARITY_EN
    output logic [2:0]      state_out
`else
    output logic [1:0]      state_out
`endif
);

    // Handshake: rx_done_tick is high for exactly one clk; rx_dout, frame_err and
    // parity_err change on that same edge and hold until the next rx_done_tick.

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;
`endif

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);

    state_t            state_reg, state_next;
    logic [3:0]        s_reg, s_next;
    logic [NW-1:0]     n_reg, n_next;
    logic [DBIT-1:0]   b_reg, b_next;
    logic [DBIT-1:0]   dout_next;
    logic              done_next;
    logic              ferr_next;
    logic              sync1, rx_s;

`ifdef UART_RX_PARITY_EN
    logic pbit_reg, pbit_next;
    logic perr_next;
`endif

    // Synchronizer flops reset high so a reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            s_reg        <= '0;
            n_reg        <= '0;
            b_reg        <= '0;
            rx_dout      <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            s_reg        <= s_next;
            n_reg        <= n_next;
            b_reg        <= b_next;
            rx_dout      <= dout_next;
            rx_done_tick <= done_next;
            frame_err    <= ferr_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pbit_reg   <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            pbit_reg   <= pbit_next;
            parity_err <= perr_next;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        dout_next  = rx_dout;
        done_next  = 1'b0;
        ferr_next  = frame_err;
`ifdef UART_RX_PARITY_EN
        pbit_next  = pbit_reg;
        perr_next  = parity_err;
`endif
        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                // Mid start bit: a line already back high was only a glitch.
                if (s_tick) begin
                    if (s_reg == 4'd7) begin
                        s_next = '0;
                        if (!rx_s) begin
                            state_next = DATA;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == 4'd15) begin
                        s_next = '0;
                        b_next = {rx_s, b_reg[DBIT-1:1]};
                        if (n_reg == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n_reg + 1'b1;
                        end
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_reg == 4'd15) begin
                        s_next     = '0;
                        pbit_next  = rx_s;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_reg == S_STOP) begin
                        state_next = IDLE;
                        s_next     = '0;
                        dout_next  = b_reg;
                        ferr_next  = ~rx_s;
                        done_next  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_next  = (^b_reg) ^ pbit_reg;
`endif
                    end else begin
                        s_next = s_reg + 4'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                s_next     = '0;
            end
        endcase
    end

    assign state_out = state_reg;

endmodule
